apb_mem_responder: RTL and testbench

APB4 completer (slave) that terminates the APB side of the AXI-to-APB bridge path. It presents a word-addressed register/memory array with programmable wait states, byte strobes, address/lock error responses and saturating transaction counters. It is used as the synthesizable responder in bridge integration benches, replacing random pready/prdata stimulus, and as a scratch peripheral in SoC configurations.

---
 rtl/apb_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_apb_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_responder.sv
// apb_mem_responder
//
// APB4 completer backed by a word-addressed memory array. Each transfer is
// captured in its setup cycle (direction, address, data, strobes, wait count
// and write-lock), then completes after the programmed number of wait states.
// Misaligned, out-of-range and locked writes complete with pslverr. Three
// saturating counters track completed OK reads, OK writes and error transfers.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   psel, penable        APB select / access-phase enable
//   pwrite, paddr        direction (1=write), byte address
//   pwdata, pstrb        write data, write byte strobes
//   prdata, pready       read data, transfer completion
//   pslverr              error response (only meaningful with pready)
//   wait_cfg             wait states per access, sampled in the setup cycle
//   wr_lock              reject all writes, sampled in the setup cycle
//   rd_cnt, wr_cnt       completed OK reads / writes (saturating)
//   err_cnt              completed error transfers (saturating)

module apb_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            pstrb,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [3:0]            wait_cfg,
    input  logic                  wr_lock,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // StDone is never entered in normal operation; it falls straight back to
    // idle so a corrupted state register recovers within one cycle.
    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            strb_q, strb_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  mem_we;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    // Setup-phase decode
    logic [31:0]     setup_word;
    logic            setup_err;
    logic [IdxW-1:0] setup_idx;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        setup_word = 32'(paddr[ADDR_WIDTH-1:2]);
        setup_idx  = paddr[IdxW+1:2];
        setup_err  = (paddr[1:0] != 2'b00) || (setup_word >= DEPTH_WORDS) ||
                     (pwrite && wr_lock);
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        err_d     = err_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        wcnt_d    = wcnt_q;
        rbuf_d    = rbuf_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        mem_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // penable without a preceding setup is ignored
                if (psel && !penable) begin
                    write_d = pwrite;
                    err_d   = setup_err;
                    idx_d   = setup_idx;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    wcnt_d  = wait_cfg;
                    rbuf_d  = (!pwrite && !setup_err) ? mem_q[setup_idx] : '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!psel) begin
                    // Abort: drop the transfer without side effects
                    state_d = StIdle;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else if (penable) begin
                    if (err_q) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else if (write_q) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = sat_inc(wr_cnt_q);
                    end else begin
                        rd_cnt_d = sat_inc(rd_cnt_q);
                    end
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            wcnt_q    <= '0;
            rbuf_q    <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            wcnt_q    <= wcnt_d;
            rbuf_q    <= rbuf_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Memory array with byte-granular writes at completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Outputs decode registered state only; no path from APB inputs
    always_comb begin
        pready  = (state_q == StAccess) && (wcnt_q == 4'd0);
        pslverr = pready && err_q;
        prdata  = (pready && !err_q && !write_q) ? rbuf_q : '0;
        rd_cnt  = rd_cnt_q;
        wr_cnt  = wr_cnt_q;
        err_cnt = err_cnt_q;
    end

endmodule

// File: tb/tb_apb_mem_responder.sv
module tb_apb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  wait_cfg = '0;
    logic        wr_lock = 1'b0;
    logic [15:0] rd_cnt, wr_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array plus counters
    logic [31:0] ref_mem [256];
    int m_rd = 0, m_wr = 0, m_err = 0;

    apb_mem_responder #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .DEPTH_WORDS(256),
        .CNT_WIDTH  (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .wait_cfg(wait_cfg),
        .wr_lock (wr_lock),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic bit model_err(input bit wr, input logic [11:0] a, input bit lock);
        int ai = int'(a);
        return (ai % 4 != 0) || (ai / 4 >= 256) || (wr && lock);
    endfunction

    function automatic logic [31:0] model_rdata(input bit wr, input logic [11:0] a, input bit e);
        if (e || wr) return 32'h0;
        return ref_mem[int'(a) / 4];
    endfunction

    task automatic model_commit(input bit wr, input logic [11:0] a, input logic [31:0] d,
                                input logic [3:0] s, input bit e);
        if (e) begin
            m_err = sat(m_err);
        end else if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[int'(a) / 4][8*b +: 8] = d[8*b +: 8];
            end
            m_wr = sat(m_wr);
        end else begin
            m_rd = sat(m_rd);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        m_rd = 0;
        m_wr = 0;
        m_err = 0;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, " rd_cnt"}, 32'(rd_cnt), 32'(m_rd));
        chk({tag, " wr_cnt"}, 32'(wr_cnt), 32'(m_wr));
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(m_err));
    endtask

    // One APB transfer. Called #1 after a rising edge; returns #1 after the
    // completion edge with psel dropped, so consecutive calls are back-to-back.
    task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] wt, input bit lock,
                        output logic [31:0] rdata, output bit err, output int lat);
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = d;
        pstrb = s;
        wait_cfg = wt;
        wr_lock = lock;
        chk("setup pready", 32'(pready), 32'h0);
        @(posedge clk);
        #1;
        penable = 1'b1;
        // Sampled only at setup: these changes must not alter the transfer
        wait_cfg = ~wt;
        wr_lock = ~lock;
        lat = 1;
        while (pready !== 1'b1 && lat < 40) begin
            chk("wait prdata", prdata, 32'h0);
            chk("wait pslverr", 32'(pslverr), 32'h0);
            @(posedge clk);
            #1;
            lat++;
        end
        if (pready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout: pready not seen after %0d cycles", lat);
        end
        rdata = prdata;
        err = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
    endtask

    task automatic run_model(input string name, input bit wr, input logic [11:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input logic [3:0] wt, input bit lock);
        logic [31:0] rd;
        bit          e;
        int          lat;
        bit          exp_e = model_err(wr, a, lock);
        logic [31:0] exp_rd = model_rdata(wr, a, exp_e);
        xfer(wr, a, d, s, wt, lock, rd, e, lat);
        chk({name, " pslverr"}, 32'(e), 32'(exp_e));
        chk({name, " prdata"}, rd, exp_rd);
        chk({name, " latency"}, 32'(lat), 32'(wt) + 32'd1);
        model_commit(wr, a, d, s, exp_e);
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  wt;
        bit          lock;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] rd;
        bit          e;
        int          lat;

        vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 4'd0, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 4'd0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 4'd0, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 12'h020, 32'h0,        4'h0, 4'd0, 1'b0, 32'h00BB00DD, 1'b0};
        vecs[4]  = '{1'b0, 12'h010, 32'h0,        4'h0, 4'd3, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b0, 12'h011, 32'h0,        4'h0, 4'd0, 1'b0, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 12'h400, 32'h0,        4'h0, 4'd0, 1'b0, 32'h0, 1'b1};
        vecs[7]  = '{1'b1, 12'h010, 32'h11112222, 4'hF, 4'd0, 1'b1, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 12'h010, 32'h0,        4'h0, 4'd0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b1, 12'h020, 32'h12345678, 4'h0, 4'd1, 1'b0, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 12'h020, 32'h0,        4'h0, 4'd0, 1'b0, 32'h00BB00DD, 1'b0};
        vecs[11] = '{1'b1, 12'h3FC, 32'hCAFEF00D, 4'hA, 4'd2, 1'b0, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 12'h3FC, 32'h0,        4'h0, 4'd1, 1'b0, 32'hCA00F000, 1'b0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset pready", 32'(pready), 32'h0);
        chk("reset pslverr", 32'(pslverr), 32'h0);
        chk("reset prdata", prdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_counters("reset");

        // Directed table, issued back-to-back
        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].wt,
                 vecs[i].lock, rd, e, lat);
            chk($sformatf("vec%0d pslverr", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].wt) + 32'd1);
            model_commit(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                         vecs[i].exp_err);
            if (i == 1) begin
                chk("first pair wr_cnt", 32'(wr_cnt), 32'd1);
                chk("first pair rd_cnt", 32'(rd_cnt), 32'd1);
                chk("first pair err_cnt", 32'(err_cnt), 32'd0);
            end
        end
        chk("table wr_cnt", 32'(wr_cnt), 32'd4);
        chk("table rd_cnt", 32'(rd_cnt), 32'd6);
        chk("table err_cnt", 32'(err_cnt), 32'd3);

        // penable in idle without setup is ignored
        psel = 1'b1;
        penable = 1'b1;
        pwrite = 1'b1;
        paddr = 12'h010;
        pwdata = 32'h0;
        pstrb = 4'hF;
        wait_cfg = 4'd0;
        wr_lock = 1'b0;
        @(posedge clk);
        #1;
        chk("idle penable pready", 32'(pready), 32'h0);
        @(posedge clk);
        #1;
        chk("idle penable pready2", 32'(pready), 32'h0);
        psel = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        chk_counters("idle penable");

        // Abort a 5-wait write after two access cycles
        psel = 1'b1;
        pwrite = 1'b1;
        paddr = 12'h010;
        pwdata = 32'h0;
        pstrb = 4'hF;
        wait_cfg = 4'd5;
        @(posedge clk);
        #1;
        penable = 1'b1;
        chk("abort pready1", 32'(pready), 32'h0);
        @(posedge clk);
        #1;
        chk("abort pready2", 32'(pready), 32'h0);
        psel = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort pready after", 32'(pready), 32'h0);
        chk_counters("abort");
        run_model("abort readback", 1'b0, 12'h010, 32'h0, 4'h0, 4'd0, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            bit          wr = 1'($urandom_range(0, 1));
            int          sel = $urandom_range(0, 15);
            logic [11:0] a;
            if (sel == 0) a = 12'(12'h400 + $urandom_range(0, 255) * 4);
            else if (sel == 1) a = 12'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else a = 12'($urandom_range(0, 31) * 4);
            run_model($sformatf("rand%0d", n), wr, a, $urandom, 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        chk_counters("random");

        // Reset in the middle of a waited write
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 12'h3FC;
        pwdata = 32'h55AA55AA;
        pstrb = 4'hF;
        wait_cfg = 4'd5;
        wr_lock = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset pready", 32'(pready), 32'h0);
        chk("midreset pslverr", 32'(pslverr), 32'h0);
        chk("midreset prdata", prdata, 32'h0);
        model_reset();
        chk_counters("midreset");
        psel = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_model("post reset 0x3FC", 1'b0, 12'h3FC, 32'h0, 4'h0, 4'd0, 1'b0);
        run_model("post reset 0x010", 1'b0, 12'h010, 32'h0, 4'h0, 4'd2, 1'b0);
        chk_counters("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
